// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller sitting in front of a dual_port_ram: port A is
// the write port, port B the read port. Owns pointers, occupancy and flags.
// Optional sticky overflow/underflow flags are built when DPRAM_FIFO_ERR_EN
// is defined; otherwise err_ovf/err_udf are tied low.
module dpram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_out_b,
  output logic                  err_ovf,
  output logic                  err_udf
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  // Flags decoded from registered occupancy only.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Accept decisions; reset gating keeps the RAM write disabled while rst=0.
  assign push = wr_valid & ~full & rst;
  assign pop  = rd_en & ~empty & rst;

  assign wr_ready   = ~full & rst;
  assign ram_we_a   = push;
  assign ram_addr_a = wr_ptr;
  assign ram_data_a = wr_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_ptr;

  // RAM output register is the data stage; zero it outside valid cycles.
  assign rd_data = rd_valid ? ram_out_b : '0;

  // Pointer, occupancy and read-valid state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DPRAM_FIFO_ERR_EN
  // Sticky error flags: any push attempt while full, any pop attempt while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (wr_valid && full) err_ovf <= 1'b1;
      if (rd_en && empty)   err_udf <= 1'b1;
    end
  end
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural RAM plus a queue-based FIFO model.
// Error-flag expectations follow DPRAM_FIFO_ERR_EN.
module tb_dpram_fifo_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ram_we_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_data_a;
  logic          ram_we_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_out_b;
  logic          err_ovf;
  logic          err_udf;

  dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count(count),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_out_b(ram_out_b),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  // Plain dual-port storage: write on A, registered read on B.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_out_b <= mem[ram_addr_b];
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [DW-1:0] q[$];
  int            wa;
  int            ra;
  bit            exp_valid;
  logic [DW-1:0] exp_data;
  bit            m_ovf;
  bit            m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_err();
`ifdef DPRAM_FIFO_ERR_EN
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
    chk("err_udf", 32'(err_udf), 32'(m_udf));
`else
    chk("err_ovf", 32'(err_ovf), 32'(0));
    chk("err_udf", 32'(err_udf), 32'(0));
`endif
  endtask

  function automatic void model_clear();
    q.delete();
    wa = 0;
    ra = 0;
    exp_valid = 1'b0;
    exp_data = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endfunction

  // One clock of stimulus; checks the state left by the previous edge and
  // the combinational RAM controls for this cycle, then advances the model.
  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit re);
    bit f, e, ep, eo;
    @(negedge clk);
    wr_valid = wv; wr_data = wd; rd_en = re;
    #1;
    f  = (q.size() == DEPTH);
    e  = (q.size() == 0);
    ep = wv && !f;
    eo = re && !e;
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(f));
    chk("empty", 32'(empty), 32'(e));
    chk("wr_ready", 32'(wr_ready), 32'(!f));
    chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (exp_valid) chk("rd_data", 32'(rd_data), 32'(exp_data));
    else           chk("rd_data_idle", 32'(rd_data), 32'(0));
    chk("ram_we_a", 32'(ram_we_a), 32'(ep));
    chk("ram_we_b", 32'(ram_we_b), 32'(0));
    if (ep) begin
      chk("ram_addr_a", 32'(ram_addr_a), 32'(wa));
      chk("ram_data_a", 32'(ram_data_a), 32'(wd));
    end
    if (eo) chk("ram_addr_b", 32'(ram_addr_b), 32'(ra));
    chk_err();
    if (wv && f) m_ovf = 1'b1;
    if (re && e) m_udf = 1'b1;
    exp_valid = eo;
    if (eo) begin
      exp_data = q.pop_front();
      ra = (ra + 1) % DEPTH;
    end
    if (ep) begin
      q.push_back(wd);
      wa = (wa + 1) % DEPTH;
    end
  endtask

  // Hold reset two cycles with a push and pop requested; nothing may move.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b1; wr_data = 8'h77; rd_en = 1'b1;
    repeat (2) begin
      #1;
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_empty", 32'(empty), 32'(1));
      chk("rst_full", 32'(full), 32'(0));
      chk("rst_wr_ready", 32'(wr_ready), 32'(0));
      chk("rst_ram_we_a", 32'(ram_we_a), 32'(0));
      chk("rst_rd_valid", 32'(rd_valid), 32'(0));
      chk("rst_rd_data", 32'(rd_data), 32'(0));
      chk("rst_err_ovf", 32'(err_ovf), 32'(0));
      chk("rst_err_udf", 32'(err_udf), 32'(0));
      @(posedge clk);
      #1;
      chk("rst_ram_we_a_edge", 32'(ram_we_a), 32'(0));
      @(negedge clk);
    end
    wr_valid = 1'b0; rd_en = 1'b0;
    rst = 1'b1;
    model_clear();
  endtask

  initial begin
    model_clear();
    do_reset();

    // Fill 0..63, then an overflowing push.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    // Full with push+pop: only the pop is accepted.
    step(1'b1, 8'hBB, 1'b1);
    step(1'b1, 8'd63, 1'b0);
    // Drain everything, observe the last word and the empty state.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    // Pop while empty.
    step(1'b0, 8'h00, 1'b1);
    // Empty with push+pop: only the push lands.
    step(1'b1, 8'hC0, 1'b1);
    for (int i = 1; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    // Steady occupancy of 5 with simultaneous traffic.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hD0 + i), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Pointer wrap from a clean start.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 8'(i + 200), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(100 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 120; i++) begin
        if (ph % 2 == 0)
          step(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) == 0);
        else
          step(($urandom % 4) == 0, 8'($urandom), ($urandom % 4) != 0);
      end
    end

    // Reset mid-operation discards contents and clears sticky flags.
    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
